// File: rtl/cordicpol2cart.sv
// Rotation-mode CORDIC polar->Cartesian converter, one micro-rotation per pipeline stage, global stall.
// Define CORDIC_POL2CART_GAIN_COMP_EN to append a gain-compensation multiply stage (latency +1).

module cordicpol2cart_stage #(
  parameter int XW    = 19,
  parameter int ZW    = 12,
  parameter int SHIFT = 0,
  parameter int ATAN  = 0
) (
  input  logic [XW-1:0] i_x,
  input  logic [XW-1:0] i_y,
  input  logic [ZW-1:0] i_z,
  output logic [XW-1:0] o_x,
  output logic [XW-1:0] o_y,
  output logic [ZW-1:0] o_z
);
  logic signed [XW-1:0] w_xs, w_ys;
  logic                 w_pos;

  assign w_xs  = $signed(i_x) >>> SHIFT;
  assign w_ys  = $signed(i_y) >>> SHIFT;
  assign w_pos = ~i_z[ZW-1];

  // Rotate toward z=0: positive residual rotates counter-clockwise.
  assign o_x = w_pos ? i_x - w_ys : i_x + w_ys;
  assign o_y = w_pos ? i_y + w_xs : i_y - w_xs;
  assign o_z = w_pos ? i_z - ZW'(ATAN) : i_z + ZW'(ATAN);
endmodule

module cordicpol2cart #(
  parameter int ITERATIONS = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH:0]   r_in,
  input  logic [ITERATIONS:0]   theta_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH+2:0] xout,
  output logic [DATA_WIDTH+2:0] yout
);
  localparam int XW = DATA_WIDTH + 3;
  localparam int ZW = ITERATIONS + 5;
  localparam int TW = ITERATIONS + 1;
`ifdef CORDIC_POL2CART_GAIN_COMP_EN
  localparam int STAGES = ITERATIONS + 2;
`else
  localparam int STAGES = ITERATIONS + 1;
`endif

  // atan(2^-i) in z units (full circle = 2^ZW), Taylor series at elaboration.
  function automatic int atan_lsb(input int i);
    real x, t, s, a;
    x = 1.0;
    for (int k = 0; k < i; k++) x = x / 2.0;
    s = 0.0;
    t = x;
    for (int n = 0; n < 60; n++) begin
      if (n % 2 == 0) s = s + t / real'(2 * n + 1);
      else            s = s - t / real'(2 * n + 1);
      t = t * x * x;
    end
    a = (i == 0) ? 0.78539816339744831 : s;
    return $rtoi(a * real'(1 << ZW) / 6.28318530717958648 + 0.5);
  endfunction

  logic                         w_en;
  logic [STAGES-1:0]            r_vld_pipe;
  logic [ITERATIONS:0][XW-1:0]  w_x, w_y, r_x, r_y;
  logic [ITERATIONS:0][ZW-1:0]  w_z, r_z;
  logic [XW-1:0]                w_r, w_x0, w_y0;
  logic [1:0]                   w_q;
  logic                         w_unused;

  assign w_en      = ~out_valid | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_vld_pipe[STAGES-1];

  // Quadrant pre-rotation leaves a residual angle in [0, 90deg).
  assign w_q = theta_in[TW-1:TW-2];
  assign w_r = {2'b00, r_in};

  always_comb begin
    w_x0 = '0;
    w_y0 = '0;
    case (w_q)
      2'd0:    w_x0 = w_r;
      2'd1:    w_y0 = w_r;
      2'd2:    w_x0 = -w_r;
      default: w_y0 = -w_r;
    endcase
  end

  assign w_x[0] = w_x0;
  assign w_y[0] = w_y0;
  assign w_z[0] = {2'b00, theta_in[TW-3:0], 4'b0000};

  for (genvar k = 1; k <= ITERATIONS; k++) begin : g_stage
    cordicpol2cart_stage #(
      .XW   (XW),
      .ZW   (ZW),
      .SHIFT(k - 1),
      .ATAN (atan_lsb(k - 1))
    ) u_stage (
      .i_x(r_x[k-1]),
      .i_y(r_y[k-1]),
      .i_z(r_z[k-1]),
      .o_x(w_x[k]),
      .o_y(w_y[k]),
      .o_z(w_z[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
    end else if (w_en) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-2:0], in_valid};
      r_x        <= w_x;
      r_y        <= w_y;
      r_z        <= w_z;
    end
  end

`ifdef CORDIC_POL2CART_GAIN_COMP_EN
  function automatic int gain_c();
    real p, f, k;
    p = 1.0;
    f = 1.0;
    for (int i = 0; i < ITERATIONS; i++) begin
      p = p * (1.0 + f);
      f = f / 4.0;
    end
    k = p;
    for (int n = 0; n < 40; n++) k = 0.5 * (k + p / k);
    return $rtoi(32768.0 / k + 0.5);
  endfunction

  localparam int GC = gain_c();

  logic signed [XW+16:0] w_px, w_py;
  logic [XW-1:0]         r_xo, r_yo;

  // Q15 multiply by 1/K with round-half-up before the shift.
  assign w_px = $signed(r_x[ITERATIONS]) * $signed(17'(GC)) + $signed((XW+17)'(16384));
  assign w_py = $signed(r_y[ITERATIONS]) * $signed(17'(GC)) + $signed((XW+17)'(16384));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xo <= '0;
      r_yo <= '0;
    end else if (w_en) begin
      r_xo <= w_px[XW+14:15];
      r_yo <= w_py[XW+14:15];
    end
  end

  assign xout     = r_xo;
  assign yout     = r_yo;
  assign w_unused = ^{r_z[ITERATIONS], w_px[14:0], w_px[XW+16:XW+15],
                      w_py[14:0], w_py[XW+16:XW+15]};
`else
  assign xout     = r_x[ITERATIONS];
  assign yout     = r_y[ITERATIONS];
  assign w_unused = ^r_z[ITERATIONS];
`endif
endmodule
